// File: rtl/instr_fetch_if.sv
// Host/downstream interface of the instruction sequencer: program load,
// run control, and the issued opcode/immediate stream.
interface instr_fetch_if #(
    parameter int ADDR_W = 4,
    parameter int DATA_W = 8
);
    logic                prog_we;
    logic [ADDR_W-1:0]   prog_addr;
    logic [DATA_W+3:0]   prog_data;
    logic [ADDR_W:0]     prog_len;
    logic                start;
    logic                stall;
    logic [3:0]          opcode;
    logic [DATA_W-1:0]   imediato;
    logic                instr_valid;
    logic [ADDR_W-1:0]   pc;
    logic                busy;
    logic                done;

    modport master (
        output prog_we, prog_addr, prog_data, prog_len, start, stall,
        input  opcode, imediato, instr_valid, pc, busy, done
    );

    modport slave (
        input  prog_we, prog_addr, prog_data, prog_len, start, stall,
        output opcode, imediato, instr_valid, pc, busy, done
    );
endinterface

// File: rtl/instr_fetch_seq.sv
// Instruction sequencer: loadable program memory stepped through on start,
// issuing one opcode/immediate pair per two cycles with downstream stall.
module instr_fetch_seq #(
    parameter int DEPTH  = 16,
    parameter int ADDR_W = 4,
    parameter int DATA_W = 8
) (
    input logic            clk,
    input logic            rst_n,
    instr_fetch_if.slave   bus
);
    localparam int LEN_W = ADDR_W + 1;

    typedef enum logic [1:0] {
        IDLE,
        FETCH,
        ISSUE,
        DONE
    } state_t;

    state_t              state_q;
    logic [ADDR_W-1:0]   pc_q;
    logic [LEN_W-1:0]    len_q;
    logic [3:0]          opcode_q;
    logic [DATA_W-1:0]   imm_q;
    logic                valid_q;
    logic                busy_q;
    logic                done_q;

    logic [DATA_W+3:0]   mem [DEPTH];

    logic                ctrl_open;
    logic [LEN_W-1:0]    len_clamp_d;
    logic [LEN_W-1:0]    pc_next_d;
    logic [DATA_W+3:0]   fetch_word;

    assign ctrl_open   = (state_q == IDLE) || (state_q == DONE);
    assign len_clamp_d = (bus.prog_len > LEN_W'(DEPTH)) ? LEN_W'(DEPTH) : bus.prog_len;
    assign pc_next_d   = {1'b0, pc_q} + LEN_W'(1);
    assign fetch_word  = mem[pc_q];

    // Program memory is deliberately left out of reset so a reset mid-run keeps the program.
    always_ff @(posedge clk) begin
        if (bus.prog_we && ctrl_open && ({1'b0, bus.prog_addr} < LEN_W'(DEPTH))) begin
            mem[bus.prog_addr] <= bus.prog_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            pc_q     <= '0;
            len_q    <= '0;
            opcode_q <= '0;
            imm_q    <= '0;
            valid_q  <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            case (state_q)
                IDLE, DONE: begin
                    if (bus.start) begin
                        len_q <= len_clamp_d;
                        pc_q  <= '0;
                        if (len_clamp_d == '0) begin
                            state_q <= DONE;
                            busy_q  <= 1'b0;
                            done_q  <= 1'b1;
                        end else begin
                            state_q <= FETCH;
                            busy_q  <= 1'b1;
                            done_q  <= 1'b0;
                        end
                    end
                end
                FETCH: begin
                    opcode_q <= fetch_word[DATA_W+3:DATA_W];
                    imm_q    <= fetch_word[DATA_W-1:0];
                    valid_q  <= 1'b1;
                    state_q  <= ISSUE;
                end
                ISSUE: begin
                    // The last instruction leaves pc on its own address rather than stepping past it.
                    if (!bus.stall) begin
                        valid_q <= 1'b0;
                        if (pc_next_d == len_q) begin
                            state_q <= DONE;
                            busy_q  <= 1'b0;
                            done_q  <= 1'b1;
                        end else begin
                            pc_q    <= pc_next_d[ADDR_W-1:0];
                            state_q <= FETCH;
                        end
                    end
                end
                default: begin
                    state_q <= IDLE;
                    valid_q <= 1'b0;
                    busy_q  <= 1'b0;
                    done_q  <= 1'b0;
                end
            endcase
        end
    end

    assign bus.opcode      = opcode_q;
    assign bus.imediato    = imm_q;
    assign bus.instr_valid = valid_q;
    assign bus.pc          = pc_q;
    assign bus.busy        = busy_q;
    assign bus.done        = done_q;
endmodule
